// File: rtl/array_addr_seq_pkg.sv
// rtl/array_addr_seq_pkg.sv - shared types and mode encodings for the array address sequencer
package array_addr_seq_pkg;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    typedef enum logic [1:0] {
        UP       = MODE_UP,
        DOWN     = MODE_DOWN,
        PINGPONG = MODE_PINGPONG,
        HOLD     = MODE_HOLD
    } seq_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/array_addr_seq_dwell_timer.sv
// rtl/array_addr_seq_dwell_timer.sv - counts 0..dwell and flags the last cycle of each address
import array_addr_seq_pkg::*;

module dwell_timer #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 en,
    input  logic [CNT_WIDTH-1:0] dwell,
    output logic                 expire
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // expire marks the final cycle of the current dwell period
    assign expire = en && !load && (cnt_q == dwell);

    // restart on load or after the last dwell cycle, otherwise count up while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == dwell) ? '0 : cnt_q + CNT_ONE;
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/array_addr_seq.sv
// rtl/array_addr_seq.sv - programmable up/down/ping-pong/hold address sequencer for array
import array_addr_seq_pkg::*;

module array_addr_seq #(
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] first,
    input  logic [ADDR_WIDTH-1:0] last,
    input  logic [CNT_WIDTH-1:0]  dwell,
    input  logic [CNT_WIDTH-1:0]  passes,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  addr_valid,
    output logic                  step,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    seq_state_t            state_q, state_d;
    seq_mode_t             mode_q, mode_d;
    logic [CNT_WIDTH-1:0]  dwell_q, dwell_d;
    logic [CNT_WIDTH-1:0]  passes_q, passes_d;
    logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
    logic [ADDR_WIDTH-1:0] lo_q, lo_d;
    logic [ADDR_WIDTH-1:0] hi_q, hi_d;
    logic                  dir_up_q, dir_up_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  addr_valid_q, addr_valid_d;
    logic                  step_q, step_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  timer_load;
    logic                  timer_en;
    logic                  expire;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  next_dir_up;
    logic                  pass_end;
    logic [CNT_WIDTH-1:0]  pass_inc;

    dwell_timer #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (timer_en),
        .dwell  (dwell_q),
        .expire (expire)
    );

    assign timer_en = (state_q == RUN);

    // next address along the latched range and whether the current address closes a pass
    always_comb begin
        next_addr   = addr_q;
        next_dir_up = dir_up_q;
        pass_end    = 1'b0;
        if (mode_q == HOLD || lo_q == hi_q) begin
            next_addr = lo_q;
            pass_end  = 1'b1;
        end else begin
            case (mode_q)
                UP: begin
                    pass_end  = (addr_q == hi_q);
                    next_addr = pass_end ? lo_q : addr_q + ADDR_ONE;
                end
                DOWN: begin
                    pass_end  = (addr_q == lo_q);
                    next_addr = pass_end ? hi_q : addr_q - ADDR_ONE;
                end
                default: begin
                    // ping-pong: turnaround skips the endpoint so it is not repeated
                    if (dir_up_q) begin
                        pass_end = (addr_q == hi_q);
                        if (pass_end) begin
                            next_addr   = hi_q - ADDR_ONE;
                            next_dir_up = 1'b0;
                        end else begin
                            next_addr = addr_q + ADDR_ONE;
                        end
                    end else begin
                        pass_end = (addr_q == lo_q);
                        if (pass_end) begin
                            next_addr   = lo_q + ADDR_ONE;
                            next_dir_up = 1'b1;
                        end else begin
                            next_addr = addr_q - ADDR_ONE;
                        end
                    end
                end
            endcase
        end
        pass_inc = (pass_cnt_q == '1) ? pass_cnt_q : pass_cnt_q + CNT_ONE;
    end

    // sequencer control: start latches config, stop aborts, pass count ends the run
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        dwell_d      = dwell_q;
        passes_d     = passes_q;
        pass_cnt_d   = pass_cnt_q;
        lo_d         = lo_q;
        hi_d         = hi_q;
        dir_up_d     = dir_up_q;
        addr_d       = addr_q;
        addr_valid_d = addr_valid_q;
        busy_d       = busy_q;
        step_d       = 1'b0;
        done_d       = 1'b0;
        timer_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d       = seq_mode_t'(mode);
                    dwell_d      = dwell;
                    passes_d     = passes;
                    pass_cnt_d   = '0;
                    lo_d         = (first < last) ? first : last;
                    hi_d         = (first < last) ? last : first;
                    dir_up_d     = 1'b1;
                    addr_d       = (seq_mode_t'(mode) == DOWN) ? hi_d : lo_d;
                    addr_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    step_d       = 1'b1;
                    timer_load   = 1'b1;
                    state_d      = RUN;
                end
            end
            default: begin
                if (stop) begin
                    addr_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end else if (expire) begin
                    if (pass_end) begin
                        pass_cnt_d = pass_inc;
                    end
                    if (pass_end && passes_q != '0 && pass_inc == passes_q) begin
                        addr_valid_d = 1'b0;
                        busy_d       = 1'b0;
                        done_d       = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        addr_d   = next_addr;
                        dir_up_d = next_dir_up;
                        step_d   = 1'b1;
                    end
                end
            end
        endcase
    end

    // state, configuration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mode_q       <= UP;
            dwell_q      <= '0;
            passes_q     <= '0;
            pass_cnt_q   <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            dir_up_q     <= 1'b1;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            step_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            dwell_q      <= dwell_d;
            passes_q     <= passes_d;
            pass_cnt_q   <= pass_cnt_d;
            lo_q         <= lo_d;
            hi_q         <= hi_d;
            dir_up_q     <= dir_up_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign addr       = addr_q;
    assign addr_valid = addr_valid_q;
    assign step       = step_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_array_addr_seq.sv
// tb/tb_array_addr_seq.sv - directed bench for array_addr_seq
module tb_array_addr_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [1:0] first;
    logic [1:0] last;
    logic [7:0] dwell;
    logic [7:0] passes;
    logic [1:0] addr;
    logic       addr_valid;
    logic       step;
    logic       busy;
    logic       done;

    int n_checks;
    int n_pass;
    int exp_a[$];

    array_addr_seq #(
        .ADDR_WIDTH(2),
        .CNT_WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .first      (first),
        .last       (last),
        .dwell      (dwell),
        .passes     (passes),
        .addr       (addr),
        .addr_valid (addr_valid),
        .step       (step),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [1:0] exp_addr);
        check({tag, "_addr"}, addr, exp_addr);
        check({tag, "_valid"}, addr_valid, 1'b0);
        check({tag, "_step"}, step, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    // start a sequence, walk exp_a cycle by cycle, then expect the done pulse
    task automatic run_seq(input string tag, input logic [1:0] m, input logic [1:0] f,
                           input logic [1:0] l, input logic [7:0] dw, input logic [7:0] ps);
        mode   = m;
        first  = f;
        last   = l;
        dwell  = dw;
        passes = ps;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        mode   = ~m;
        first  = ~f;
        last   = ~l;
        dwell  = 8'd5;
        passes = 8'd7;
        for (int i = 0; i < exp_a.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), addr, exp_a[i]);
            check($sformatf("%s_step%0d", tag, i), step, (i % (int'(dw) + 1)) == 0);
            check($sformatf("%s_valid%0d", tag, i), addr_valid, 1'b1);
            check($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
            check($sformatf("%s_done%0d", tag, i), done, 1'b0);
            tick();
        end
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_end_valid"}, addr_valid, 1'b0);
        check({tag, "_end_busy"}, busy, 1'b0);
        check({tag, "_end_step"}, step, 1'b0);
        check({tag, "_end_addr"}, addr, exp_a[exp_a.size() - 1]);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b1;
        stop     = 1'b0;
        mode     = 2'b00;
        first    = 2'd1;
        last     = 2'd3;
        dwell    = 8'd0;
        passes   = 8'd1;

        // reset held 3 cycles with start asserted
        tick();
        tick();
        tick();
        check_idle("reset", 2'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check_idle("post_reset", 2'd0);

        // up, two passes
        exp_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        run_seq("up", 2'b00, 2'd0, 2'd3, 8'd0, 8'd2);

        // ping-pong started in the done cycle (back-to-back)
        exp_a = '{1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 2, 2, 3, 3};
        run_seq("pp", 2'b10, 2'd1, 2'd3, 8'd1, 8'd3);
        tick();
        check_idle("pp_after", 2'd3);

        // down with swapped endpoints
        exp_a = '{3, 2, 1, 0};
        run_seq("down", 2'b01, 2'd3, 2'd0, 8'd0, 8'd1);
        tick();

        // stop with passes=0, start during RUN ignored
        mode   = 2'b00;
        first  = 2'd0;
        last   = 2'd3;
        dwell  = 8'd0;
        passes = 8'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("stop_c1_addr", addr, 2'd0);
        tick();
        check("stop_c2_addr", addr, 2'd1);
        tick();
        check("stop_c3_addr", addr, 2'd2);
        mode  = 2'b01;
        first = 2'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("stop_c4_addr", addr, 2'd3);
        check("stop_c4_step", step, 1'b1);
        tick();
        check("stop_c5_addr", addr, 2'd0);
        check("stop_c5_valid", addr_valid, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_idle("stop_c6", 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle($sformatf("stop_idle%0d", i), 2'd0);
        end

        // reset mid-run
        mode   = 2'b00;
        first  = 2'd0;
        last   = 2'd3;
        dwell  = 8'd0;
        passes = 8'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("rmid_c1_addr", addr, 2'd0);
        tick();
        tick();
        tick();
        check("rmid_c4_addr", addr, 2'd3);
        check("rmid_c4_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rmid_c5", 2'd0);

        // hold mode
        exp_a = '{2, 2, 2, 2, 2, 2};
        run_seq("hold", 2'b11, 2'd2, 2'd2, 8'd2, 8'd2);
        tick();
        check_idle("hold_after", 2'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/array_addr_seq.md
# array_addr_seq

Programmable address sequencer that drives the `addr` port of an `array` lookup block in place of a free-running counter. It walks a configurable address range in up, down, ping-pong or hold order. Each address is held for a programmable number of cycles. It stops after a programmed number of passes or on request. Outputs are registered and change only on `clk`, so the downstream `array` sees a clean, glitch-free address.

## Interface
Parameters:
- `ADDR_WIDTH`, default 2: width of `addr`, `first` and `last`; must match the downstream `array` address width.
- `CNT_WIDTH`, default 8: width of `dwell`, `passes` and the internal counters.

Ports:
- `clk` input, 1: single clock; all logic is rising-edge.
- `rst` input, 1: synchronous, active-high reset.
- `start` input, 1: begin a sequence; honoured only in IDLE.
- `stop` input, 1: abort a sequence; honoured only in RUN.
- `mode` input, 2: 00 up, 01 down, 10 ping-pong, 11 hold.
- `first` input, ADDR_WIDTH: range endpoint.
- `last` input, ADDR_WIDTH: range endpoint.
- `dwell` input, CNT_WIDTH: each address is held `dwell+1` cycles.
- `passes` input, CNT_WIDTH: number of passes; 0 means run until `stop`.
- `addr` output, ADDR_WIDTH: address to `array`.
- `addr_valid` output, 1: `addr` is part of an active sequence.
- `step` output, 1: one-cycle pulse in the first cycle of each new address.
- `busy` output, 1: in RUN.
- `done` output, 1: one-cycle pulse on natural completion.

## Operation
- States: IDLE and RUN.
- IDLE with `start`=1:
  - Latch `mode`, `dwell` and `passes`.
  - Compute `lo`=min(`first`,`last`) and `hi`=max(`first`,`last`).
  - Go to RUN.
  - Inputs changing after this point have no effect until the next start.
- Start address: lo for up, ping-pong and hold; hi for down.
- Dwell timer:
  - Counts 0..`dwell`, then the address advances and the timer restarts at 0.
  - `step` pulses in the first cycle of every address, including the start address and wrap-around repeats.
- Up mode: lo, lo+1 … hi is one pass; after hi, wrap to lo.
- Down mode: hi … lo is one pass; after lo, wrap to hi.
- Ping-pong mode:
  - Each traversal is one pass: lo→hi, then hi→lo, alternating.
  - Endpoints are not repeated at turnaround (hi is followed by hi-1).
- Hold mode, or lo==hi in any mode: the address stays at lo; each dwell period counts as one pass.
- Pass counter increments at the end of the final address of each pass.
- Completion (`passes`≠0): when the completed-pass count equals `passes`:
  - Next cycle: go to IDLE with `done`=1 for one cycle.
  - `addr_valid`=0 and `busy`=0.
  - `addr` holds the final address.
- `stop` in RUN:
  - Next cycle: go to IDLE with `addr_valid`=0 and `busy`=0.
  - `addr` holds its value; `done` stays 0.
- `stop` has priority over completion in the same cycle; `done` is not asserted.
- Ignored inputs: `start` in RUN; `stop` in IDLE. `start`=`stop`=1 in IDLE starts the sequence.
- `passes`=0: the pass counter is not compared and the sequence runs until `stop`.
- Pass counter saturates at 2^CNT_WIDTH−1 and does not wrap.
- All address arithmetic stays within ADDR_WIDTH; no overflow is possible because motion is bounded by lo/hi.

## Timing
- Reset values: `addr`=0, `addr_valid`=0, `step`=0, `busy`=0, `done`=0; state IDLE; all counters 0.
- `rst` overrides everything, including mid-sequence; outputs take reset values in the following cycle.
- Latency: `start` sampled at edge t gives the start address with `addr_valid`=`busy`=`step`=1 after edge t+1.
- After the final address's last dwell cycle, `done` is high for exactly one cycle and `start` is accepted again in that same cycle.
- Per-address period is exactly `dwell`+1 cycles.
- Back-to-back start: new sequence begins the cycle after `done`.

## Structure
- Package `array_addr_seq_pkg` holds:
  - `seq_mode_t` enum: UP, DOWN, PINGPONG, HOLD.
  - `seq_state_t` enum: IDLE, RUN.
  - Mode encoding constants.
- One sub-module, `dwell_timer`:
  - Inputs: load, `dwell` value, enable.
  - Output: `expire` pulse.
  - Reused for the dwell count.
- Pass counter, direction flag and address register live in the top module.

## Test plan
Sequences use ADDR_WIDTH=2 with `start` sampled at edge t; waveforms are compared against an `array` model.
- Reset: hold `rst`=1 for 3 cycles → all outputs 0; `start` during `rst` is ignored.
- Up: `first`=0, `last`=3, `dwell`=0, `passes`=2 → `addr` 0,1,2,3,0,1,2,3 on cycles t+1..t+8, `step`=1 every cycle, `done`=1 at t+9 with `addr`=3.
- Ping-pong: `first`=1, `last`=3, `dwell`=1, `passes`=3 → `addr` 1,1,2,2,3,3,2,2,1,1,2,2,3,3 on cycles t+1..t+14, `step` on odd cycles, `done` at t+15.
- Down with swapped endpoints: `first`=3, `last`=0, `passes`=1, `dwell`=0 → 3,2,1,0, then `done`.
- Stop: `passes`=0, up mode, `stop` at t+5 → `addr_valid`=0 at t+6, `addr` holds, `done` never asserts; a `start` at t+3 during RUN has no effect.
- Reset mid-run and hold mode:
  - `rst` at t+4 → reset values at t+5.
  - Then hold mode, `first`=2, `dwell`=2, `passes`=2 → `addr`=2 for 6 cycles, `step` at t+1 and t+4, then `done`.
